// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Words stream gaplessly when a new word is offered during the final bit.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             handshake;
    logic             head_bit;
    logic [WIDTH-1:0] shreg_shifted;

    assign last_bit  = (state == SHIFT) && (cnt == LAST);
    assign load_ready = (state == IDLE) || last_bit;
    assign handshake = load_valid && load_ready;

    // The output end of shreg depends on bit order; the vacated end fills with zero.
    assign head_bit      = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    assign ser_valid = (state == SHIFT);
    assign ser_out   = (state == SHIFT) ? head_bit : 1'b0;
    assign done      = last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (handshake) begin
            state <= SHIFT;
            shreg <= data_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            shreg <= shreg_shifted;
            if (last_bit) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: MSB-first and LSB-first instances share stimulus
// and are compared against a queue-of-remaining-bits reference model.
module tb_piso_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] data_in;
    logic         rdy_m, out_m, val_m, done_m;
    logic         rdy_l, out_l, val_l, done_l;

    int errors = 0;
    int checks = 0;

    bit qm[$];
    bit ql[$];
    bit capm[$];
    bit capl[$];
    int donesm;

    typedef struct {
        logic         rst;
        logic         lv;
        logic [W-1:0] din;
        logic         ready;
        logic         valid;
        logic         sout;
        logic         done;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_m),
        .data_in(data_in), .ser_out(out_m), .ser_valid(val_m), .done(done_m)
    );

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_l),
        .data_in(data_in), .ser_out(out_l), .ser_valid(val_l), .done(done_l)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("msb load_ready", rdy_m, qm.size() <= 1);
        checkValue("msb ser_valid", val_m, qm.size() > 0);
        checkValue("msb ser_out", out_m, (qm.size() > 0) ? qm[0] : 1'b0);
        checkValue("msb done", done_m, qm.size() == 1);
        checkValue("lsb load_ready", rdy_l, ql.size() <= 1);
        checkValue("lsb ser_valid", val_l, ql.size() > 0);
        checkValue("lsb ser_out", out_l, (ql.size() > 0) ? ql[0] : 1'b0);
        checkValue("lsb done", done_l, ql.size() == 1);
    endtask

    // Reference: each queue holds the bits still to be sent for the current word.
    task automatic modelStep(input logic rst, input logic lv, input logic [W-1:0] din);
        bit hs;
        hs = lv && (qm.size() <= 1);
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (hs) begin
                for (int i = W - 1; i >= 0; i--) qm.push_back(din[i]);
                for (int i = 0; i < W; i++) ql.push_back(din[i]);
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic lv, input logic [W-1:0] din);
        @(negedge clk);
        reset      = rst;
        load_valid = lv;
        data_in    = din;
        checkOutput();
        if (val_m === 1'b1) capm.push_back(out_m);
        if (val_l === 1'b1) capl.push_back(out_l);
        if (done_m === 1'b1) donesm++;
        modelStep(rst, lv, din);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, W'($urandom));
    endtask

    task automatic clearCapture();
        capm.delete();
        capl.delete();
        donesm = 0;
    endtask

    function automatic logic [31:0] packBits(input bit q[$]);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    initial begin
        logic [W-1:0] pat;
        pat = 8'hA5;
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < W; k++)
            tbl[3+k] = '{1'b0, 1'b0, 8'hFF, k == W - 1, 1'b1, pat[W-1-k], k == W - 1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hA5;
        donesm     = 0;
        @(posedge clk);

        // Reset with load_valid high, then a single A5 word (bit-symmetric for both orders).
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].lv, tbl[i].din);
            checkValue($sformatf("tbl[%0d] msb ready", i), rdy_m, tbl[i].ready);
            checkValue($sformatf("tbl[%0d] msb valid", i), val_m, tbl[i].valid);
            checkValue($sformatf("tbl[%0d] msb out", i), out_m, tbl[i].sout);
            checkValue($sformatf("tbl[%0d] msb done", i), done_m, tbl[i].done);
            checkValue($sformatf("tbl[%0d] lsb out", i), out_l, tbl[i].sout);
            checkValue($sformatf("tbl[%0d] lsb done", i), done_l, tbl[i].done);
        end

        // Single 01 word: order difference between the two instances.
        clearCapture();
        applyStimulus(1'b0, 1'b1, 8'h01);
        idleCycles(W + 1);
        checkValue("word01 msb bits", packBits(capm), 32'h01);
        checkValue("word01 lsb bits", packBits(capl), 32'h80);
        checkValue("word01 done count", donesm, 1);

        // Back-to-back: load_valid held high, F0 then 0F streams with no gap.
        clearCapture();
        applyStimulus(1'b0, 1'b1, 8'hF0);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, 1'b1, 8'h0F);
        idleCycles(W + 1);
        checkValue("stream msb bits", packBits(capm), 32'hF00F);
        checkValue("stream lsb bits", packBits(capl), 32'h0FF0);
        checkValue("stream bit count", capm.size(), 2 * W);
        checkValue("stream done count", donesm, 2);

        // Busy rejection: FF offered from cnt=3 is only taken at the last bit.
        clearCapture();
        applyStimulus(1'b0, 1'b1, 8'h3C);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkValue("busy load_ready", rdy_m, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'hFF);
        idleCycles(W + 1);
        checkValue("busy msb bits", packBits(capm), 32'h3CFF);
        checkValue("busy lsb bits", packBits(capl), 32'h3CFF);

        // Reset after bit 4 aborts the word without a done pulse.
        clearCapture();
        applyStimulus(1'b0, 1'b1, 8'hC3);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkValue("abort ser_valid", val_m, 1'b0);
        checkValue("abort done count", donesm, 0);
        clearCapture();
        applyStimulus(1'b0, 1'b1, 8'h81);
        idleCycles(W + 1);
        checkValue("after abort msb bits", packBits(capm), 32'h81);
        checkValue("after abort lsb bits", packBits(capl), 32'h81);
        checkValue("after abort done count", donesm, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, W'($urandom));
        idleCycles(W + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
